// File: rtl/cpu_csr_sequencer.sv
// CSR/trap sequencer: runs execute-stage CSR ops as read-modify-write on the CSR file,
// issues mret/ecall, and dispatches pending interrupts at instruction boundaries.
//
// state     | meaning
// IDLE      | arbitrate csr > mret > ecall > irq
// CSR_READ  | o_index presented, old value sampled from i_rdata
// CSR_WRITE | write strobe, ready pulse, old value returned
// MRET      | mret strobe, fetch redirected to mepc
// ECALL     | ecall strobe
// IRQ       | dispatch strobe, fetch redirected to mtvec
// IRQ_WAIT  | hold until pending drops so one interrupt dispatches once
module cpu_csr_sequencer #(
   parameter bit IRQ_ENABLE = 1'b1
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_csr_request,
   input  logic [1:0]  i_csr_op,
   input  logic [11:0] i_csr_index,
   input  logic [31:0] i_csr_operand,
   input  logic        i_csr_rs1_zero,
   output logic        o_csr_ready,
   output logic [31:0] o_csr_rdata,
   input  logic        i_mret_request,
   output logic        o_mret_ready,
   input  logic        i_ecall_request,
   output logic        o_ecall_ready,
   input  logic        i_instr_boundary,
   input  logic [31:0] i_next_pc,
   output logic        o_jump,
   output logic [31:0] o_jump_pc,
   output logic [11:0] o_index,
   input  logic [31:0] i_rdata,
   output logic        o_wdata_wr,
   output logic [31:0] o_wdata,
   output logic        o_mret,
   output logic        o_ecall,
   input  logic [31:0] i_epc,
   input  logic        i_irq_pending,
   input  logic [31:0] i_irq_pc,
   output logic        o_irq_dispatched,
   output logic [31:0] o_irq_epc
);

   localparam logic [1:0] OP_RS = 2'd2;
   localparam logic [1:0] OP_RC = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CSR_READ,
      S_CSR_WRITE,
      S_MRET,
      S_ECALL,
      S_IRQ,
      S_IRQ_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [11:0] index_q, index_d;
   logic [31:0] operand_q, operand_d;
   logic        rs1_zero_q, rs1_zero_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wdata_wr_q, wdata_wr_d;
   logic        csr_ready_q, csr_ready_d;
   logic [31:0] csr_rdata_q, csr_rdata_d;
   logic        mret_q, mret_d;
   logic        ecall_q, ecall_d;
   logic        jump_q, jump_d;
   logic [31:0] jump_pc_q, jump_pc_d;
   logic        irq_disp_q, irq_disp_d;
   logic [31:0] irq_epc_q, irq_epc_d;

   logic [31:0] new_value;
   logic        set_clear;

   always_comb begin
      set_clear = (op_q == OP_RS) || (op_q == OP_RC);
      case (op_q)
         OP_RS:   new_value = i_rdata | operand_q;
         OP_RC:   new_value = i_rdata & ~operand_q;
         default: new_value = operand_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      index_d     = index_q;
      operand_d   = operand_q;
      rs1_zero_d  = rs1_zero_q;
      wdata_d     = wdata_q;
      csr_rdata_d = csr_rdata_q;
      jump_pc_d   = jump_pc_q;
      irq_epc_d   = irq_epc_q;
      wdata_wr_d  = 1'b0;
      csr_ready_d = 1'b0;
      mret_d      = 1'b0;
      ecall_d     = 1'b0;
      jump_d      = 1'b0;
      irq_disp_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_csr_request) begin
               op_d       = i_csr_op;
               index_d    = i_csr_index;
               operand_d  = i_csr_operand;
               rs1_zero_d = i_csr_rs1_zero;
               state_d    = S_CSR_READ;
            end else if (i_mret_request) begin
               mret_d    = 1'b1;
               jump_d    = 1'b1;
               jump_pc_d = i_epc;
               state_d   = S_MRET;
            end else if (i_ecall_request) begin
               ecall_d = 1'b1;
               state_d = S_ECALL;
            end else if (IRQ_ENABLE && i_irq_pending && i_instr_boundary) begin
               irq_disp_d = 1'b1;
               irq_epc_d  = i_next_pc;
               jump_d     = 1'b1;
               jump_pc_d  = i_irq_pc;
               state_d    = S_IRQ;
            end
         end
         S_CSR_READ: begin
            // csrrs/csrrc with x0/zimm=0 are pure reads and must not write
            wdata_d     = new_value;
            wdata_wr_d  = !(set_clear && rs1_zero_q);
            csr_ready_d = 1'b1;
            csr_rdata_d = i_rdata;
            state_d     = S_CSR_WRITE;
         end
         S_CSR_WRITE: state_d = S_IDLE;
         S_MRET:      state_d = S_IDLE;
         S_ECALL:     state_d = S_IDLE;
         S_IRQ:       state_d = S_IRQ_WAIT;
         S_IRQ_WAIT: begin
            if (!i_irq_pending) state_d = S_IDLE;
         end
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         index_q     <= '0;
         operand_q   <= '0;
         rs1_zero_q  <= 1'b0;
         wdata_q     <= '0;
         wdata_wr_q  <= 1'b0;
         csr_ready_q <= 1'b0;
         csr_rdata_q <= '0;
         mret_q      <= 1'b0;
         ecall_q     <= 1'b0;
         jump_q      <= 1'b0;
         jump_pc_q   <= '0;
         irq_disp_q  <= 1'b0;
         irq_epc_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         index_q     <= index_d;
         operand_q   <= operand_d;
         rs1_zero_q  <= rs1_zero_d;
         wdata_q     <= wdata_d;
         wdata_wr_q  <= wdata_wr_d;
         csr_ready_q <= csr_ready_d;
         csr_rdata_q <= csr_rdata_d;
         mret_q      <= mret_d;
         ecall_q     <= ecall_d;
         jump_q      <= jump_d;
         jump_pc_q   <= jump_pc_d;
         irq_disp_q  <= irq_disp_d;
         irq_epc_q   <= irq_epc_d;
      end
   end

   assign o_index          = index_q;
   assign o_wdata          = wdata_q;
   assign o_wdata_wr       = wdata_wr_q;
   assign o_csr_ready      = csr_ready_q;
   assign o_csr_rdata      = csr_rdata_q;
   assign o_mret           = mret_q;
   assign o_mret_ready     = mret_q;
   assign o_ecall          = ecall_q;
   assign o_ecall_ready    = ecall_q;
   assign o_jump           = jump_q;
   assign o_jump_pc        = jump_pc_q;
   assign o_irq_dispatched = IRQ_ENABLE && irq_disp_q;
   assign o_irq_epc        = irq_epc_q;

endmodule
